// File: rtl/seq_logic_pipe.sv
// seq_logic_pipe: per-bit logic function F(A,B,C,mode) that feeds a stall-able,
// flushable pipeline. Stages alternate polarity, so Z undoes the net inversion
// and equals F captured DEPTH enabled edges earlier. A saturating counter
// tallies delivered items.

// One bit lane of the stage-1 logic function.
module seq_logic_pipe_lane (
    input  logic       a,
    input  logic       b,
    input  logic       c,
    input  logic [1:0] mode,
    output logic       f
);
    // Select the lane function from mode.
    always_comb begin
        f = 1'b0;
        case (mode)
            2'b00:   f = (a | b) & c;
            2'b01:   f = (a & b) | c;
            2'b10:   f = a ^ b ^ c;
            default: f = (a & b) | (a & c) | (b & c);
        endcase
    end
endmodule

module seq_logic_pipe #(
    parameter int WIDTH   = 4,
    parameter int DEPTH   = 2,
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic [WIDTH-1:0]   C,
    input  logic [1:0]         mode,
    input  logic               in_valid,
    input  logic               en,
    input  logic               flush,
    input  logic               clr_count,
    output logic [WIDTH-1:0]   Z,
    output logic               out_valid,
    output logic [COUNT_W-1:0] out_count
);
    logic [WIDTH-1:0]            f;
    logic [DEPTH:1][WIDTH-1:0]   stage_q, stage_d;
    logic [DEPTH:1]              vld_pipe_q, vld_pipe_d;
    logic [COUNT_W-1:0]          cnt_q, cnt_d;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        seq_logic_pipe_lane u_lane (
            .a    (A[i]),
            .b    (B[i]),
            .c    (C[i]),
            .mode (mode),
            .f    (f[i])
        );
    end

    // Advance data and valid shift registers on enable; flush kills every valid bit.
    always_comb begin
        stage_d    = stage_q;
        vld_pipe_d = vld_pipe_q;
        if (en) begin
            stage_d[1] = f;
            for (int k = 2; k <= DEPTH; k++)
                stage_d[k] = ~stage_q[k-1];
            vld_pipe_d = {vld_pipe_q[DEPTH-1:1], in_valid};
        end
        if (flush)
            vld_pipe_d = '0;
    end

    // Count items leaving the pipe; clear wins, the count sticks at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_count)
            cnt_d = '0;
        else if (vld_pipe_q[DEPTH] && en && (cnt_q != '1))
            cnt_d = cnt_q + COUNT_W'(1);
    end

    // State registers with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q    <= '0;
            vld_pipe_q <= '0;
            cnt_q      <= '0;
        end else begin
            stage_q    <= stage_d;
            vld_pipe_q <= vld_pipe_d;
            cnt_q      <= cnt_d;
        end
    end

    // An even stage count leaves the data inverted once more than an odd one.
    assign Z         = (DEPTH % 2 == 1) ? stage_q[DEPTH] : ~stage_q[DEPTH];
    assign out_valid = vld_pipe_q[DEPTH];
    assign out_count = cnt_q;
endmodule

// File: tb/tb_seq_logic_pipe.sv
// Bench for seq_logic_pipe: three instances share stimulus (default, COUNT_W=3,
// DEPTH=3). A scoreboard queue per data instance holds expected Z values.
module tb_seq_logic_pipe;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] A = '0, B = '0, C = '0;
    logic [1:0] mode = '0;
    logic       in_valid = 1'b0, en = 1'b1, flush = 1'b0, clr_count = 1'b0;

    logic [3:0] z0, z1, z2;
    logic       ov0, ov1, ov2;
    logic [7:0] cnt0, cnt2;
    logic [2:0] cnt1;

    int total = 0;
    int bad   = 0;

    logic [3:0] q0[$];
    logic [3:0] q2[$];
    logic       ov0_s = 1'b0, ov2_s = 1'b0;

    seq_logic_pipe #(.WIDTH(4), .DEPTH(2), .COUNT_W(8)) u0 (
        .clk(clk), .rst(rst), .A(A), .B(B), .C(C), .mode(mode), .in_valid(in_valid),
        .en(en), .flush(flush), .clr_count(clr_count), .Z(z0), .out_valid(ov0), .out_count(cnt0));
    seq_logic_pipe #(.WIDTH(4), .DEPTH(2), .COUNT_W(3)) u1 (
        .clk(clk), .rst(rst), .A(A), .B(B), .C(C), .mode(mode), .in_valid(in_valid),
        .en(en), .flush(flush), .clr_count(clr_count), .Z(z1), .out_valid(ov1), .out_count(cnt1));
    seq_logic_pipe #(.WIDTH(4), .DEPTH(3), .COUNT_W(8)) u2 (
        .clk(clk), .rst(rst), .A(A), .B(B), .C(C), .mode(mode), .in_valid(in_valid),
        .en(en), .flush(flush), .clr_count(clr_count), .Z(z2), .out_valid(ov2), .out_count(cnt2));

    initial forever #5 clk = ~clk;

    function automatic logic [3:0] model_f(input logic [3:0] a, input logic [3:0] b,
                                           input logic [3:0] c, input logic [1:0] m);
        logic [3:0] r;
        int n;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            n = int'(a[i]) + int'(b[i]) + int'(c[i]);
            case (m)
                2'd0: r[i] = (a[i] || b[i]) && c[i];
                2'd1: r[i] = (a[i] && b[i]) || c[i];
                2'd2: r[i] = (n % 2) == 1;
                default: r[i] = n >= 2;
            endcase
        end
        return r;
    endfunction

    // Scoreboard update at the active edge: retire delivered items, accept new ones.
    initial forever begin
        @(posedge clk);
        if (rst) begin
            q0.delete(); q2.delete();
        end else begin
            if (en && ov0_s && q0.size() > 0) void'(q0.pop_front());
            if (en && ov2_s && q2.size() > 0) void'(q2.pop_front());
            if (flush) begin
                q0.delete(); q2.delete();
            end else if (en && in_valid) begin
                q0.push_back(model_f(A, B, C, mode));
                q2.push_back(model_f(A, B, C, mode));
            end
        end
    end

    // Output monitor on the falling edge: every valid Z must match the queue head.
    initial forever begin
        @(negedge clk);
        ov0_s = (ov0 === 1'b1);
        ov2_s = (ov2 === 1'b1);
        if (ov0_s) begin
            total++;
            if (q0.size() == 0) begin
                bad++; $display("FAIL sb_d2 unexpected out_valid Z=%h", z0);
            end else if (z0 !== q0[0]) begin
                bad++; $display("FAIL sb_d2 Z got %b want %b", z0, q0[0]);
            end
        end
        if (ov2_s) begin
            total++;
            if (q2.size() == 0) begin
                bad++; $display("FAIL sb_d3 unexpected out_valid Z=%h", z2);
            end else if (z2 !== q2[0]) begin
                bad++; $display("FAIL sb_d3 Z got %b want %b", z2, q2[0]);
            end
        end
    end

    task automatic do_reset();
        in_valid = 1'b0; flush = 1'b0; clr_count = 1'b0; en = 1'b1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        // Competing controls held active during reset must not matter.
        in_valid = 1'b1; en = 1'b1; clr_count = 1'b1; flush = 1'b0; rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0; in_valid = 1'b0; clr_count = 1'b0;
        total++; if (ov0 !== 1'b0) begin bad++; $display("FAIL rst_ov got %b want 0", ov0); end
        total++; if (z0 !== 4'hF) begin bad++; $display("FAIL rst_z_d2 got %h want f", z0); end
        total++; if (cnt0 !== 8'd0) begin bad++; $display("FAIL rst_cnt got %0d want 0", cnt0); end
        total++; if (cnt1 !== 3'd0) begin bad++; $display("FAIL rst_cnt_w3 got %0d want 0", cnt1); end
        total++; if (z2 !== 4'h0) begin bad++; $display("FAIL rst_z_d3 got %h want 0", z2); end
        total++; if (ov2 !== 1'b0) begin bad++; $display("FAIL rst_ov_d3 got %b want 0", ov2); end
    endtask

    task automatic test_basic();
        A = 4'b0011; B = 4'b0101; C = 4'b1110; mode = 2'b00; in_valid = 1'b1;
        @(negedge clk); in_valid = 1'b0;
        @(negedge clk);
        total++; if (ov0 !== 1'b1) begin bad++; $display("FAIL basic_ov got %b want 1", ov0); end
        total++; if (z0 !== 4'b0110) begin bad++; $display("FAIL basic_z got %b want 0110", z0); end
        total++; if (ov2 !== 1'b0) begin bad++; $display("FAIL basic_ov_d3_early got %b want 0", ov2); end
        @(negedge clk);
        total++; if (ov0 !== 1'b0) begin bad++; $display("FAIL basic_ov_drop got %b want 0", ov0); end
        total++; if (cnt0 !== 8'd1) begin bad++; $display("FAIL basic_cnt got %0d want 1", cnt0); end
        total++; if (ov2 !== 1'b1) begin bad++; $display("FAIL basic_ov_d3 got %b want 1", ov2); end
        total++; if (z2 !== 4'b0110) begin bad++; $display("FAIL basic_z_d3 got %b want 0110", z2); end
        @(negedge clk);
        total++; if (cnt2 !== 8'd1) begin bad++; $display("FAIL basic_cnt_d3 got %0d want 1", cnt2); end
    endtask

    task automatic test_all_modes();
        mode = 2'b01; in_valid = 1'b1;
        @(negedge clk); mode = 2'b10;
        @(negedge clk);
        total++; if (z0 !== 4'b1111 || ov0 !== 1'b1) begin bad++; $display("FAIL mode01 got %b/%b want 1111/1", z0, ov0); end
        mode = 2'b11;
        @(negedge clk);
        total++; if (z0 !== 4'b1000 || ov0 !== 1'b1) begin bad++; $display("FAIL mode10 got %b/%b want 1000/1", z0, ov0); end
        in_valid = 1'b0;
        @(negedge clk);
        total++; if (z0 !== 4'b0111 || ov0 !== 1'b1) begin bad++; $display("FAIL mode11 got %b/%b want 0111/1", z0, ov0); end
        @(negedge clk);
        total++; if (ov0 !== 1'b0) begin bad++; $display("FAIL modes_ov_drop got %b want 0", ov0); end
        total++; if (cnt0 !== 8'd4) begin bad++; $display("FAIL modes_cnt got %0d want 4", cnt0); end
    endtask

    task automatic test_stall();
        do_reset();
        A = 4'b0011; B = 4'b0101; C = 4'b1110; mode = 2'b00; in_valid = 1'b1;
        @(negedge clk); in_valid = 1'b0; en = 1'b0;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            total++; if (ov0 !== 1'b0 || z0 !== 4'b0000) begin
                bad++; $display("FAIL stall_hold%0d got %b/%b want 0000/0", s, z0, ov0);
            end
            in_valid = 1'b1;   // offered during a stall, must be ignored
        end
        total++; if (cnt0 !== 8'd0) begin bad++; $display("FAIL stall_cnt_hold got %0d want 0", cnt0); end
        en = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        total++; if (ov0 !== 1'b1 || z0 !== 4'b0110) begin bad++; $display("FAIL stall_out got %b/%b want 0110/1", z0, ov0); end
        @(negedge clk);
        total++; if (ov0 !== 1'b0) begin bad++; $display("FAIL stall_once got %b want 0", ov0); end
        total++; if (cnt0 !== 8'd1) begin bad++; $display("FAIL stall_cnt got %0d want 1", cnt0); end
    endtask

    task automatic test_flush();
        A = 4'b1010; B = 4'b0110; C = 4'b0001; mode = 2'b10; in_valid = 1'b1;
        @(negedge clk); flush = 1'b1;   // item offered alongside the flush is dropped too
        @(negedge clk); flush = 1'b0; in_valid = 1'b0;
        for (int s = 0; s < 3; s++) begin
            total++; if (ov0 !== 1'b0 || ov2 !== 1'b0) begin
                bad++; $display("FAIL flush_ov%0d got %b/%b want 0/0", s, ov0, ov2);
            end
            @(negedge clk);
        end
        total++; if (cnt0 !== 8'd1) begin bad++; $display("FAIL flush_cnt got %0d want 1", cnt0); end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 9; i++) begin
            A = 4'($urandom); B = 4'($urandom); C = 4'($urandom); mode = 2'($urandom);
            in_valid = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (cnt1 !== 3'd7) begin bad++; $display("FAIL sat_cnt got %0d want 7", cnt1); end
        total++; if (cnt0 !== 8'd9) begin bad++; $display("FAIL sat_cnt_wide got %0d want 9", cnt0); end
        A = 4'b0011; B = 4'b0101; C = 4'b1110; mode = 2'b00; in_valid = 1'b1;
        @(negedge clk); in_valid = 1'b0;
        @(negedge clk);
        total++; if (ov1 !== 1'b1) begin bad++; $display("FAIL clr_pre_ov got %b want 1", ov1); end
        clr_count = 1'b1;
        @(negedge clk); clr_count = 1'b0;
        total++; if (cnt1 !== 3'd0) begin bad++; $display("FAIL clr_prio got %0d want 0", cnt1); end
        total++; if (cnt0 !== 8'd0) begin bad++; $display("FAIL clr_prio_wide got %0d want 0", cnt0); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_all_modes();
        test_stall();
        test_flush();
        test_saturation();
        repeat (4) @(negedge clk);
        total++; if (q0.size() != 0) begin bad++; $display("FAIL sb_d2_drain got %0d want 0", q0.size()); end
        total++; if (q2.size() != 0) begin bad++; $display("FAIL sb_d3_drain got %0d want 0", q2.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/seq_logic_pipe.md
SEQ_LOGIC_PIPE -- requirements
Module: seq_logic_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 4: bit width of each data channel (bitwise lanes, ≥1).
REQ-002 SHALL have parameter DEPTH, default 2: number of register stages, legal range 2..16.
REQ-003 SHALL have parameter COUNT_W, default 8: width of the output-transfer counter (≥2).
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have ports A, B, C, input, WIDTH bits each: operand vectors.
REQ-007 SHALL have port mode, input, 2 bits: stage-1 logic function select.
REQ-008 SHALL have port in_valid, input, 1 bit: A/B/C/mode qualify as a new item.
REQ-009 SHALL have port en, input, 1 bit: pipeline advance enable; 0 = stall.
REQ-010 SHALL have port flush, input, 1 bit: discard all in-flight items.
REQ-011 SHALL have port clr_count, input, 1 bit: clear out_count.
REQ-012 SHALL have port Z, output, WIDTH bits: pipeline result.
REQ-013 SHALL have port out_valid, output, 1 bit: Z holds a valid item.
REQ-014 SHALL have port out_count, output, COUNT_W bits: number of valid items delivered.

Function
REQ-015 SHALL compute F combinationally per bit: mode 00 (A|B)&C; 01 (A&B)|C; 10 A^B^C; 11 majority(A,B,C).
REQ-016 SHALL, when en=1, load stage[1] <= F and stage[k] <= ~stage[k-1] for k=2..DEPTH.
REQ-017 SHALL drive Z = stage[DEPTH] when DEPTH is odd, ~stage[DEPTH] when DEPTH is even, so Z equals F captured DEPTH enabled edges earlier.
REQ-018 SHALL carry a valid bit alongside each stage: v[1] <= in_valid, v[k] <= v[k-1] when en=1; out_valid = v[DEPTH].
REQ-019 SHALL hold all data and valid stages unchanged while en=0; in_valid during a stall cycle is ignored.
REQ-020 SHALL give latency of exactly DEPTH enabled cycles from in_valid sample to out_valid; throughput is one item per enabled cycle.
REQ-021 SHALL, on flush=1, clear all valid bits at the next edge regardless of en; data stages advance per en; the item offered in the same cycle is discarded.
REQ-022 SHALL leave Z unmasked: Z reflects stage contents even when out_valid=0.
REQ-023 SHALL increment out_count by 1 on each edge where out_valid=1 and en=1, saturating at all-ones (no wrap).
REQ-024 SHALL give clr_count priority over increment in the same cycle (result 0); flush does not affect out_count.
REQ-025 SHALL sample mode with its item: a mode change takes effect on the item of the same cycle only; in-flight items are unaffected.

Reset
REQ-026 SHALL, on rst=1 at a clock edge, set all stage[k]=0, all v[k]=0 and out_count=0; rst has priority over en, flush and clr_count.
REQ-027 SHALL give post-reset outputs out_valid=0, out_count=0, Z=0 for odd DEPTH and Z=all-ones for even DEPTH.
REQ-028 SHALL accept a new item on the first edge after rst deasserts; items in flight when rst asserts are lost.

Verification (WIDTH=4, DEPTH=2 unless stated)
REQ-029 SHALL cover reset: rst=1 for 2 cycles -> out_valid=0, Z=4'hF, out_count=0.
REQ-030 SHALL cover basic transfer: mode=00, A=0011, B=0101, C=1110, in_valid=1 for 1 cycle, en=1 -> 2 edges later Z=0110, out_valid=1 for 1 cycle, out_count=1.
REQ-031 SHALL cover all modes: same operands, modes 01, 10, 11 back-to-back -> Z=1111, 1000, 0111 on consecutive cycles, out_count advances by 3.
REQ-032 SHALL cover stall: item injected, then en=0 for 3 cycles -> Z and out_valid frozen; out_valid rises 5 cycles after injection; out_count counts the item once.
REQ-033 SHALL cover flush: flush=1 one cycle after injection -> out_valid never rises; out_count unchanged.
REQ-034 SHALL cover saturation and clear priority: COUNT_W=3, 9 consecutive valid items -> out_count=7; then clr_count=1 with out_valid=1 -> out_count=0. Also repeat REQ-030 with DEPTH=3: Z=0110 after 3 edges, post-reset Z=0000.
